// File: rtl/vga_ordered_dither.sv
// Pixel-rate colour reduction from IN_WIDTH to OUT_WIDTH bits, by saturation or 4x4 Bayer dithering.
// Colour and sync share a 2 pix_ce latency; pix_ce=0 freezes every register (no other backpressure).
module vga_ordered_dither #(
    parameter int IN_WIDTH    = 6,
    parameter int OUT_WIDTH   = 4,
    parameter int MODE        = 1,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pix_ce,
    input  logic [IN_WIDTH-1:0]  in_r,
    input  logic [IN_WIDTH-1:0]  in_g,
    input  logic [IN_WIDTH-1:0]  in_b,
    input  logic                 in_hsync,
    input  logic                 in_vsync,
    output logic [OUT_WIDTH-1:0] vga_r,
    output logic [OUT_WIDTH-1:0] vga_g,
    output logic [OUT_WIDTH-1:0] vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs
);
    localparam int SHIFT = IN_WIDTH - OUT_WIDTH;
    localparam int SW    = IN_WIDTH + 1;
    localparam logic [SW-1:0] OUT_MAX = SW'((1 << OUT_WIDTH) - 1);
    localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

    if (SHIFT < 1 || SHIFT > 4) begin : g_bad_shift
        $error("vga_ordered_dither: IN_WIDTH-OUT_WIDTH must be in 1..4");
    end

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'h0: v = 4'd0;
            4'h1: v = 4'd8;
            4'h2: v = 4'd2;
            4'h3: v = 4'd10;
            4'h4: v = 4'd12;
            4'h5: v = 4'd4;
            4'h6: v = 4'd14;
            4'h7: v = 4'd6;
            4'h8: v = 4'd3;
            4'h9: v = 4'd11;
            4'hA: v = 4'd1;
            4'hB: v = 4'd9;
            4'hC: v = 4'd15;
            4'hD: v = 4'd7;
            4'hE: v = 4'd13;
            default: v = 4'd5;
        endcase
        return v;
    endfunction

    logic       hs_prev;
    logic       vs_prev;
    logic       h_edge;
    logic       v_edge;
    logic [1:0] x;
    logic [1:0] y;
    logic [3:0] thr;

    assign h_edge = (in_hsync == SYNC_ACTIVE) && (hs_prev == SYNC_IDLE);
    assign v_edge = (in_vsync == SYNC_ACTIVE) && (vs_prev == SYNC_IDLE);
    assign thr    = bayer(y, x) >> (4 - SHIFT);

    // Phase follows the undelayed syncs; a vsync edge overrides the line increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x       <= 2'd0;
            y       <= 2'd0;
            hs_prev <= SYNC_IDLE;
            vs_prev <= SYNC_IDLE;
        end else if (pix_ce) begin
            hs_prev <= in_hsync;
            vs_prev <= in_vsync;
            if (h_edge) x <= 2'd0;
            else        x <= x + 2'd1;
            if (v_edge)      y <= 2'd0;
            else if (h_edge) y <= y + 2'd1;
        end
    end

    logic [IN_WIDTH-1:0]  chan_in [3];
    logic [SW-1:0]        s_next  [3];
    logic [SW-1:0]        s_d     [3];
    logic [SW-1:0]        scaled  [3];
    logic [OUT_WIDTH-1:0] q_next  [3];
    logic [OUT_WIDTH-1:0] q_d     [3];
    logic                 hs_d;
    logic                 vs_d;

    assign chan_in[0] = in_r;
    assign chan_in[1] = in_g;
    assign chan_in[2] = in_b;

    // One extra sum bit keeps full-scale plus threshold from wrapping to zero.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            s_next[c] = SW'(chan_in[c]);
            scaled[c] = s_d[c];
            if (MODE == 1) begin
                s_next[c] = SW'(chan_in[c]) + SW'(thr);
                scaled[c] = s_d[c] >> SHIFT;
            end
            q_next[c] = (scaled[c] > OUT_MAX) ? '1 : scaled[c][OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < 3; c++) begin
                s_d[c] <= '0;
                q_d[c] <= '0;
            end
            hs_d   <= SYNC_IDLE;
            vs_d   <= SYNC_IDLE;
            vga_hs <= SYNC_IDLE;
            vga_vs <= SYNC_IDLE;
        end else if (pix_ce) begin
            for (int c = 0; c < 3; c++) begin
                s_d[c] <= s_next[c];
                q_d[c] <= q_next[c];
            end
            hs_d   <= in_hsync;
            vs_d   <= in_vsync;
            vga_hs <= hs_d;
            vga_vs <= vs_d;
        end
    end

    assign vga_r = q_d[0];
    assign vga_g = q_d[1];
    assign vga_b = q_d[2];

endmodule

// File: tb/tb_vga_ordered_dither.sv
// Bench for vga_ordered_dither: dither (MODE=1) and saturate (MODE=0) instances share one stimulus.
// A per-pixel behavioural model is compared every cycle; directed literals pin the model.
module tb_vga_ordered_dither;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pix_ce;
    logic [5:0] in_r, in_g, in_b;
    logic       in_hsync, in_vsync;
    logic [3:0] d1_r, d1_g, d1_b, d0_r, d0_g, d0_b;
    logic       d1_hs, d1_vs, d0_hs, d0_vs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_ordered_dither #(.IN_WIDTH(6), .OUT_WIDTH(4), .MODE(1), .SYNC_ACTIVE(1'b0)) dut (
        .clk(clk), .resetn(resetn), .pix_ce(pix_ce),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .vga_r(d1_r), .vga_g(d1_g), .vga_b(d1_b), .vga_hs(d1_hs), .vga_vs(d1_vs)
    );

    vga_ordered_dither #(.IN_WIDTH(6), .OUT_WIDTH(4), .MODE(0), .SYNC_ACTIVE(1'b0)) dut_sat (
        .clk(clk), .resetn(resetn), .pix_ce(pix_ce),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .vga_r(d0_r), .vga_g(d0_g), .vga_b(d0_b), .vga_hs(d0_hs), .vga_vs(d0_vs)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic int dith(input int v, input int px, input int py);
        int t;
        int q;
        t = bayer[py][px] / 4;
        q = (v + t) / 4;
        return (q > 15) ? 15 : q;
    endfunction

    int m_x, m_y;
    bit m_hprev, m_vprev;
    int pin [3];
    int mid1 [3], out1 [3], mid0 [3], out0 [3];
    bit hs_mid, hs_out, vs_mid, vs_out;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_x = 0; m_y = 0; m_hprev = 1; m_vprev = 1;
            hs_mid = 1; hs_out = 1; vs_mid = 1; vs_out = 1;
            for (int c = 0; c < 3; c++) begin
                mid1[c] = 0; out1[c] = 0; mid0[c] = 0; out0[c] = 0;
            end
        end else if (pix_ce) begin
            pin[0] = int'(in_r); pin[1] = int'(in_g); pin[2] = int'(in_b);
            for (int c = 0; c < 3; c++) begin
                out1[c] = mid1[c];
                mid1[c] = dith(pin[c], m_x, m_y);
                out0[c] = mid0[c];
                mid0[c] = (pin[c] > 15) ? 15 : pin[c];
            end
            hs_out = hs_mid; hs_mid = in_hsync;
            vs_out = vs_mid; vs_mid = in_vsync;
            if (!in_hsync && m_hprev) begin
                m_x = 0;
                m_y = (m_y + 1) % 4;
            end else begin
                m_x = (m_x + 1) % 4;
            end
            if (!in_vsync && m_vprev) m_y = 0;
            m_hprev = in_hsync;
            m_vprev = in_vsync;
        end
    end

    always @(negedge clk) begin
        chk("cmp_dith_r", int'(d1_r), out1[0]);
        chk("cmp_dith_g", int'(d1_g), out1[1]);
        chk("cmp_dith_b", int'(d1_b), out1[2]);
        chk("cmp_dith_hs", int'(d1_hs), int'(hs_out));
        chk("cmp_dith_vs", int'(d1_vs), int'(vs_out));
        chk("cmp_sat_r", int'(d0_r), out0[0]);
        chk("cmp_sat_g", int'(d0_g), out0[1]);
        chk("cmp_sat_b", int'(d0_b), out0[2]);
        chk("cmp_sat_hs", int'(d0_hs), int'(hs_out));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lit_r[$], lit_g[$], lit_b[$];

    task automatic pix(input int r, input int g, input int b, input bit hs, input bit vs,
                       input int er, input int eg, input int eb);
        in_r = 6'(r); in_g = 6'(g); in_b = 6'(b);
        in_hsync = hs; in_vsync = vs; pix_ce = 1'b1;
        lit_r.push_back(er); lit_g.push_back(eg); lit_b.push_back(eb);
        tick();
        if (lit_r.size() >= 2) begin
            chk("pat_r", int'(d1_r), lit_r.pop_front());
            chk("pat_g", int'(d1_g), lit_g.pop_front());
            chk("pat_b", int'(d1_b), lit_b.pop_front());
        end
    endtask

    int rows [4][4] = '{'{1, 1, 1, 1}, '{2, 1, 2, 1}, '{1, 1, 1, 1}, '{2, 1, 2, 1}};

    initial begin
        int lows;
        int exp_hs;
        pix_ce = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1;
        in_r = '0; in_g = '0; in_b = '0;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_r = 6'($urandom); in_g = 6'($urandom); in_b = 6'($urandom);
            in_hsync = 1'($urandom); in_vsync = 1'($urandom);
            tick();
        end
        chk("rst_r", int'(d1_r), 0);
        chk("rst_b", int'(d1_b), 0);
        chk("rst_hs", int'(d1_hs), 1);
        chk("rst_vs", int'(d1_vs), 1);
        chk("rst_sat_g", int'(d0_g), 0);

        in_hsync = 1'b1; in_vsync = 1'b1;
        resetn = 1'b1;
        in_r = 6'd9; in_g = 6'd16; in_b = 6'd63;
        tick();
        chk("lat_first_enable", int'(d0_r), 0);
        in_r = '0; in_g = '0; in_b = '0;
        tick();
        chk("sat_9", int'(d0_r), 9);
        chk("sat_16", int'(d0_g), 15);
        chk("sat_63", int'(d0_b), 15);
        chk("dith_9_t0", int'(d1_r), 2);
        chk("dith_16_t0", int'(d1_g), 4);
        chk("dith_63_t0", int'(d1_b), 15);

        // Frame: simultaneous h/v edge, then 4 lines of 4 pixels; g full-scale, b zero.
        lit_r.delete(); lit_g.delete(); lit_b.delete();
        for (int line = 0; line < 4; line++) begin
            pix(0, 0, 0, 1'b0, (line == 0) ? 1'b0 : 1'b1, 0, 0, 0);
            for (int k = 0; k < 4; k++)
                pix(5, 63, 0, 1'b1, 1'b1, rows[line][k], 15, 0);
        end
        pix(0, 0, 0, 1'b1, 1'b1, 0, 0, 0);
        lit_r.delete(); lit_g.delete(); lit_b.delete();

        // pix_ce toggling with a 3-enable hsync pulse.
        lows = 0;
        for (int e = 1; e <= 12; e++) begin
            in_hsync = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
            in_vsync = 1'b1;
            in_r = 6'(e); in_g = '0; in_b = '0;
            pix_ce = 1'b1;
            tick();
            exp_hs = (e - 1 >= 3 && e - 1 <= 5) ? 0 : 1;
            if (!d1_hs) lows++;
            if (e >= 2) begin
                chk("ce_hs", int'(d1_hs), exp_hs);
                chk("ce_sat_r", int'(d0_r), e - 1);
            end
            pix_ce = 1'b0;
            in_r = 6'd63; in_hsync = 1'($urandom); in_vsync = 1'($urandom);
            tick();
            if (e >= 2) begin
                chk("ce_hold_hs", int'(d1_hs), exp_hs);
                chk("ce_hold_r", int'(d0_r), e - 1);
            end
        end
        chk("ce_hs_low_count", lows, 3);

        // Mid-frame reset while the delayed sync is active.
        pix_ce = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1; in_r = 6'd20;
        tick();
        in_hsync = 1'b0;
        tick();
        tick();
        chk("pre_rst_hs", int'(d1_hs), 0);
        chk("pre_rst_sat_r", int'(d0_r), 15);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_hs", int'(d1_hs), 1);
        chk("async_rst_r", int'(d1_r), 0);
        chk("async_rst_sat_r", int'(d0_r), 0);
        for (int i = 0; i < 3; i++) begin
            in_r = 6'($urandom); in_hsync = 1'($urandom);
            tick();
        end
        in_hsync = 1'b1; in_vsync = 1'b1;
        resetn = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_r = 6'($urandom); in_g = 6'($urandom); in_b = 6'($urandom);
            in_hsync = (i % 6 == 2) ? 1'b0 : 1'b1;
            in_vsync = (i == 9) ? 1'b0 : 1'b1;
            pix_ce = (i % 5 != 4);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
